exc_cause_unit: RTL and testbench



---
 rtl/exc_pkg.sv | 23 ++
 rtl/exc_prio_enc.sv | 25 ++
 rtl/exc_cause_unit.sv | 87 ++++++++
 tb/tb_exc_cause_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception cause path: FSM state encoding,
// default code/vector bases and the index-width helper.
`default_nettype none

package exc_pkg;

  typedef logic [1:0] exc_state_t;

  localparam exc_state_t ST_IDLE  = 2'd0;
  localparam exc_state_t ST_HOLD  = 2'd1;
  localparam exc_state_t ST_DRAIN = 2'd2;

  localparam int unsigned EXC_BASE_CODE = 1;
  localparam int unsigned EXC_VEC_BASE  = 253;

  // A single source still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/exc_cause_unit.sv
// Sticky exception pending register with fixed-priority selection and a
// hold/ack handshake towards the control FSM.
`default_nettype none

module exc_cause_unit
  import exc_pkg::*;
#(
  parameter int                N_CAUSES  = 3,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] BASE_CODE = DATA_W'(EXC_BASE_CODE),
  parameter logic [DATA_W-1:0] VEC_BASE  = DATA_W'(EXC_VEC_BASE),
  parameter int                CNT_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CAUSES-1:0] exc_req,
  input  logic [N_CAUSES-1:0] exc_mask,
  input  logic                exc_ack,
  output logic                exc_valid,
  output logic [DATA_W-1:0]   cause_code,
  output logic [DATA_W-1:0]   vec_addr,
  output logic [N_CAUSES-1:0] pending,
  output logic [CNT_W-1:0]    lost_cnt
);

  localparam int IW = idx_width(N_CAUSES);

  exc_state_t          state;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       idx_sel;
  logic                any_pending;
  logic [N_CAUSES-1:0] set_bits;
  logic [N_CAUSES-1:0] clr;
  logic                collide;

  exc_prio_enc #(
    .N  (N_CAUSES),
    .IW (IW)
  ) u_prio (
    .req (pending),
    .idx (idx_sel),
    .any (any_pending)
  );

  assign set_bits = exc_req & ~exc_mask;
  assign clr      = (state == ST_HOLD && exc_ack) ? (N_CAUSES'(1) << idx_r) : '0;
  // A request on a bit being cleared this edge re-arms it and is not lost.
  assign collide  = |(set_bits & pending & ~clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx_r      <= '0;
      pending    <= '0;
      exc_valid  <= 1'b0;
      cause_code <= '0;
      vec_addr   <= '0;
      lost_cnt   <= '0;
    end else begin
      pending <= (pending & ~clr) | set_bits;
      if (collide && lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (any_pending) begin
            state      <= ST_HOLD;
            idx_r      <= idx_sel;
            exc_valid  <= 1'b1;
            cause_code <= BASE_CODE + DATA_W'(idx_sel);
            vec_addr   <= VEC_BASE + DATA_W'(idx_sel);
          end
        end
        ST_HOLD: begin
          if (exc_ack) begin
            state     <= ST_DRAIN;
            exc_valid <= 1'b0;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_cause_unit.sv
// Self-checking bench for exc_cause_unit: directed table, corner sequences
// and randomized traffic against an abstract reference model.
`default_nettype none

module tb_exc_cause_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  exc_req;
  logic [2:0]  exc_mask;
  logic        exc_ack;
  logic        exc_valid;
  logic [31:0] cause_code;
  logic [31:0] vec_addr;
  logic [2:0]  pending;
  logic [1:0]  lost_cnt;

  int n_pass  = 0;
  int n_total = 0;

  exc_cause_unit #(
    .N_CAUSES (3),
    .DATA_W   (32),
    .CNT_W    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exc_req    (exc_req),
    .exc_mask   (exc_mask),
    .exc_ack    (exc_ack),
    .exc_valid  (exc_valid),
    .cause_code (cause_code),
    .vec_addr   (vec_addr),
    .pending    (pending),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-source flags, the source in service (-1 = none)
  // and a one-cycle writeback bubble after each acknowledge.
  int m_pend[3];
  int m_srv   = -1;
  int m_bub   = 0;
  int m_valid = 0;
  int m_code  = 0;
  int m_vec   = 0;
  int m_lost  = 0;

  task automatic model_edge(input logic r, input logic [2:0] q, input logic [2:0] m,
                            input logic a);
    int clr_i;
    int first;
    bit hit;
    if (r) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
      m_srv = -1; m_bub = 0; m_valid = 0; m_code = 0; m_vec = 0; m_lost = 0;
      return;
    end
    clr_i = (m_srv >= 0 && a) ? m_srv : -1;
    first = -1;
    for (int i = 0; i < 3; i++) if (m_pend[i] != 0 && first < 0) first = i;
    hit = 0;
    for (int i = 0; i < 3; i++)
      if (q[i] && !m[i] && m_pend[i] != 0 && i != clr_i) hit = 1;
    if (hit && m_lost < 3) m_lost++;
    for (int i = 0; i < 3; i++)
      m_pend[i] = ((m_pend[i] != 0 && i != clr_i) || (q[i] && !m[i])) ? 1 : 0;
    if (m_srv >= 0) begin
      if (a) begin m_srv = -1; m_valid = 0; m_bub = 1; end
    end else if (m_bub != 0) begin
      m_bub = 0;
    end else if (first >= 0) begin
      m_srv = first; m_valid = 1; m_code = 1 + first; m_vec = 253 + first;
    end
  endtask

  function automatic logic [69:0] dut_pack();
    return {exc_valid, cause_code, vec_addr, pending, lost_cnt};
  endfunction

  function automatic logic [69:0] model_pack();
    logic [2:0] p;
    for (int i = 0; i < 3; i++) p[i] = (m_pend[i] != 0);
    return {m_valid[0], 32'(m_code), 32'(m_vec), p, 2'(m_lost)};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic [2:0] q, input logic [2:0] m,
                      input logic a);
    reset = r; exc_req = q; exc_mask = m; exc_ack = a;
    @(posedge clk);
    model_edge(r, q, m, a);
    #1;
    chk("model", dut_pack(), model_pack());
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  mask;
    logic        ack;
    logic        e_valid;
    logic [31:0] e_code;
    logic [31:0] e_vec;
    logic [2:0]  e_pend;
    logic [1:0]  e_lost;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1'b1; exc_req = '0; exc_mask = '0; exc_ack = 1'b0;

    // Reset with all requests active, then one cause through a full service.
    tbl[0] = '{1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0,   3'b000, 2'd0};
    tbl[1] = '{1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0,   3'b000, 2'd0};
    tbl[2] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0,   3'b000, 2'd0};
    tbl[3] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0,   3'b010, 2'd0};
    tbl[4] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 32'd2, 32'd254, 3'b010, 2'd0};
    tbl[5] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 32'd2, 32'd254, 3'b010, 2'd0};
    tbl[6] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 32'd2, 32'd254, 3'b000, 2'd0};
    tbl[7] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'd2, 32'd254, 3'b000, 2'd0};
    tbl[8] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 32'd2, 32'd254, 3'b000, 2'd0};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].ack);
      chk($sformatf("tbl%0d", i), dut_pack(),
          {tbl[i].e_valid, tbl[i].e_code, tbl[i].e_vec, tbl[i].e_pend, tbl[i].e_lost});
    end

    // Priority and hold: a higher-priority arrival does not disturb HOLD.
    step(0, 3'b100, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);
    chk("prio_first", {exc_valid, cause_code, vec_addr}, {1'b1, 32'd3, 32'd255});
    step(0, 3'b001, 3'b000, 0);
    chk("prio_pend", 70'(pending), 70'(3'b101));
    step(0, 3'b000, 3'b000, 0);
    chk("prio_hold", {exc_valid, cause_code, vec_addr}, {1'b1, 32'd3, 32'd255});
    step(0, 3'b000, 3'b000, 1);
    chk("prio_ack", {exc_valid, pending}, {1'b0, 3'b001});
    step(0, 3'b000, 3'b000, 0);
    chk("prio_drain", 70'(exc_valid), 70'(1'b0));
    step(0, 3'b000, 3'b000, 0);
    chk("prio_second", {exc_valid, cause_code, vec_addr}, {1'b1, 32'd1, 32'd253});
    step(0, 3'b000, 3'b000, 1);
    step(0, 3'b000, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);

    // Set wins over clear on the acknowledged bit.
    step(0, 3'b010, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);
    step(0, 3'b010, 3'b000, 1);
    chk("setwin_pend", {exc_valid, pending, lost_cnt}, {1'b0, 3'b010, 2'd0});
    step(0, 3'b000, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);
    chk("setwin_again", {exc_valid, cause_code}, {1'b1, 32'd2});
    step(0, 3'b000, 3'b000, 1);
    step(0, 3'b000, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);

    // Masking blocks latching only; an already pending bit is still served.
    step(0, 3'b001, 3'b001, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 3'b000, 3'b001, 0);
      chk("mask_block", {exc_valid, pending}, {1'b0, 3'b000});
    end
    step(0, 3'b001, 3'b000, 0);
    step(0, 3'b000, 3'b001, 0);
    chk("mask_late", {exc_valid, cause_code}, {1'b1, 32'd1});
    step(0, 3'b000, 3'b001, 1);
    step(0, 3'b000, 3'b000, 0);
    step(0, 3'b000, 3'b000, 0);

    // Saturating lost counter, then reset while an exception is held.
    step(0, 3'b001, 3'b000, 0);
    for (int i = 0; i < 5; i++) step(0, 3'b001, 3'b000, 0);
    chk("sat_lost", {exc_valid, cause_code, lost_cnt}, {1'b1, 32'd1, 2'd3});
    step(1, 3'b000, 3'b000, 0);
    chk("rst_hold", dut_pack(), 70'd0);
    step(0, 3'b000, 3'b000, 0);
    chk("rst_after", {exc_valid, pending}, {1'b0, 3'b000});

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [2:0] q;
      logic [2:0] m;
      logic       a;
      r = ($urandom % 60) == 0;
      q = (($urandom % 3) == 0) ? 3'($urandom) : 3'b000;
      m = (($urandom % 5) == 0) ? 3'($urandom) : 3'b000;
      a = ($urandom % 3) == 0;
      step(r, q, m, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
